port_tog_sched: RTL and testbench



---
 rtl/port_tog_sched.sv | 189 ++++++++++++++++++
 tb/tb_port_tog_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_tog_sched.sv
// port_tog_sched: periodic hardware toggle scheduler for one 8-bit port register.
// Issues tog commands carrying a bit mask every P+1 cycles, N times or until
// stopped, and merges them with the CPU write path (CPU always has priority).
module port_tog_sched #(
    parameter int p_cnt_width = 16,
    parameter int p_rpt_width = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   cfg_we,
    input  logic [p_cnt_width-1:0] cfg_period,
    input  logic [7:0]             cfg_mask,
    input  logic [p_rpt_width-1:0] cfg_count,
    input  logic                   start,
    input  logic                   stop,
    input  logic [7:0]             cpu_wdata,
    input  logic                   cpu_wbe,
    input  logic                   cpu_tog,
    output logic [7:0]             wdata,
    output logic                   wbe,
    output logic                   tog,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun,
    output logic [p_rpt_width-1:0] remaining,
    output logic                   dbg_state
);

    // Port write arbitration: the port register accepts a command in any cycle
    // where wbe or tog is high (it is always ready). A pending scheduler
    // request (req_q) acts as "valid"; it is granted in a cycle only when the
    // CPU is not strobing wbe/tog. An ungranted request stays pending; an
    // expiry landing on a still-pending request is merged and flagged in
    // overrun rather than queued.

    typedef enum logic {
        st_idle = 1'b0,
        st_run  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Configuration captured while idle.
    logic [p_cnt_width-1:0] per_q;
    logic [7:0]             msk_q;
    logic [p_rpt_width-1:0] num_q;

    // Run-time counters and flags.
    logic [p_cnt_width-1:0] cnt_q;
    logic [p_rpt_width-1:0] rpt_q;
    logic                   req_q;
    logic                   overrun_q;
    logic                   done_q;

    // Decoded events for the current cycle.
    logic in_run;
    logic cpu_act;
    logic grant;
    logic expiry;
    logic start_ok;
    logic finite;
    logic last_grant;

    assign in_run     = (state_q == st_run);
    assign cpu_act    = cpu_wbe | cpu_tog;
    assign grant      = in_run & req_q & ~cpu_act;
    assign expiry     = in_run & (cnt_q == '0);
    // stop beats start; start while running is ignored.
    assign start_ok   = ~in_run & start & ~stop;
    // cfg_count of zero selects run-until-stopped.
    assign finite     = (num_q != '0);
    assign last_grant = grant & finite & (rpt_q == p_rpt_width'(1));

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: run until stopped or the final toggle is granted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            st_idle: begin
                if (start_ok) begin
                    state_d = st_run;
                end
            end
            st_run: begin
                if (stop || last_grant) begin
                    state_d = st_idle;
                end
            end
            default: begin
                state_d = st_idle;
            end
        endcase
    end

    // Output logic: status flags and the CPU-priority port write mux.
    always_comb begin
        busy      = in_run;
        dbg_state = (state_q == st_run);
        done      = done_q;
        overrun   = overrun_q;
        remaining = finite ? rpt_q : '0;
        if (cpu_act) begin
            wdata = cpu_wdata;
            wbe   = cpu_wbe;
            tog   = cpu_tog;
        end else if (req_q) begin
            wdata = msk_q;
            wbe   = 1'b0;
            tog   = 1'b1;
        end else begin
            wdata = 8'h00;
            wbe   = 1'b0;
            tog   = 1'b0;
        end
    end

    // Configuration registers: writable only while idle so a run never sees
    // its period, mask or count change underneath it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            per_q <= '0;
            msk_q <= 8'h00;
            num_q <= '0;
        end else if (cfg_we && !in_run) begin
            per_q <= cfg_period;
            msk_q <= cfg_mask;
            num_q <= cfg_count;
        end
    end

    // Interval counter, repeat counter, request and overrun tracking.
    // The interval counter free-runs from the start edge, so a grant delayed
    // by CPU traffic does not shift the cadence of later expiries.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q     <= '0;
            rpt_q     <= '0;
            req_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else if (start_ok) begin
            cnt_q     <= per_q;
            rpt_q     <= num_q;
            req_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else if (in_run) begin
            if (stop) begin
                // Abort: drop any pending request; a grant in this same
                // cycle has already reached the port through the mux.
                req_q <= 1'b0;
            end else begin
                if (expiry) begin
                    cnt_q <= per_q;
                end else begin
                    cnt_q <= cnt_q - p_cnt_width'(1);
                end
                if (grant && finite) begin
                    rpt_q <= rpt_q - p_rpt_width'(1);
                end
                if (last_grant) begin
                    req_q <= 1'b0;
                end else begin
                    req_q <= expiry | (req_q & ~grant);
                end
                if (expiry && req_q && !grant) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    // Completion pulse: one cycle after the final grant of a finite run.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= in_run & ~stop & last_grant;
        end
    end

endmodule

// File: tb/tb_port_tog_sched.sv
// tb_port_tog_sched: directed scoreboard bench for port_tog_sched.
// Stimulus pushes expected port events (cycle, wbe, tog, wdata) and expected
// done cycles; a negedge monitor pops and compares whenever the DUT drives
// the port or pulses done.
module tb_port_tog_sched;

    logic        clk;
    logic        nrst;
    logic        cfg_we;
    logic [15:0] cfg_period;
    logic [7:0]  cfg_mask;
    logic [7:0]  cfg_count;
    logic        start;
    logic        stop;
    logic [7:0]  cpu_wdata;
    logic        cpu_wbe;
    logic        cpu_tog;
    logic [7:0]  wdata;
    logic        wbe;
    logic        tog;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [7:0]  remaining;
    logic        dbg_state;

    int cyc;
    int total = 0;
    int bad = 0;
    int k;

    logic [41:0] exp_q[$];
    int          done_q[$];
    logic [41:0] mon_e;
    logic [41:0] mon_got;
    int          mon_d;

    port_tog_sched #(
        .p_cnt_width(16),
        .p_rpt_width(8)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .cfg_we(cfg_we),
        .cfg_period(cfg_period),
        .cfg_mask(cfg_mask),
        .cfg_count(cfg_count),
        .start(start),
        .stop(stop),
        .cpu_wdata(cpu_wdata),
        .cpu_wbe(cpu_wbe),
        .cpu_tog(cpu_tog),
        .wdata(wdata),
        .wbe(wbe),
        .tog(tog),
        .busy(busy),
        .done(done),
        .overrun(overrun),
        .remaining(remaining),
        .dbg_state(dbg_state)
    );

    // Clock and cycle counter: cyc names the cycle following each rising edge.
    initial begin
        clk = 1'b0;
        cyc = 0;
        forever begin
            #5 clk = 1'b1;
            cyc = cyc + 1;
            #5 clk = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_port(input int c, input logic w, input logic t, input logic [7:0] d);
        exp_q.push_back({32'(c), w, t, d});
    endtask

    task automatic push_done(input int c);
        done_q.push_back(c);
    endtask

    task automatic do_cfg(input logic [15:0] p, input logic [7:0] m, input logic [7:0] n);
        cfg_we     = 1'b1;
        cfg_period = p;
        cfg_mask   = m;
        cfg_count  = n;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic do_start(output int k0);
        start = 1'b1;
        tick();
        start = 1'b0;
        k0 = cyc;
    endtask

    // Monitor: every port command and every done pulse must match the head
    // of its expected queue, including the cycle it appears in.
    always @(negedge clk) begin
        if (tog || wbe || (wdata != 8'h00)) begin
            total++;
            mon_got = {32'(cyc), wbe, tog, wdata};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL port_unexpected: got cyc=%0d wbe=%b tog=%b wdata=%h expected no port command",
                         cyc, wbe, tog, wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e !== mon_got) begin
                    bad++;
                    $display("FAIL port_event: got cyc=%0d wbe=%b tog=%b wdata=%h expected cyc=%0d wbe=%b tog=%b wdata=%h",
                             cyc, wbe, tog, wdata, mon_e[41:10], mon_e[9], mon_e[8], mon_e[7:0]);
                end
            end
        end
        if (done) begin
            total++;
            if (done_q.size() == 0) begin
                bad++;
                $display("FAIL done_unexpected: got done at cyc=%0d expected none", cyc);
            end else begin
                mon_d = done_q.pop_front();
                if (mon_d != cyc) begin
                    bad++;
                    $display("FAIL done_cycle: got cyc=%0d expected cyc=%0d", cyc, mon_d);
                end
            end
        end
    end

    // Watchdog so the run always ends with a summary line.
    initial begin
        repeat (5000) @(posedge clk);
        total++;
        bad++;
        $display("FAIL watchdog: got cyc=%0d expected finish before 5000", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        nrst       = 1'b0;
        cfg_we     = 1'b0;
        cfg_period = 16'h0000;
        cfg_mask   = 8'h00;
        cfg_count  = 8'h00;
        start      = 1'b0;
        stop       = 1'b0;
        cpu_wdata  = 8'h00;
        cpu_wbe    = 1'b0;
        cpu_tog    = 1'b0;

        // Reset values, then idle with no stimulus.
        to_cycle(2);
        #3;
        check("rst_wdata", wdata, 0);
        check("rst_wbe", wbe, 0);
        check("rst_tog", tog, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_remaining", remaining, 0);
        check("rst_state", dbg_state, 0);
        to_cycle(3);
        nrst = 1'b1;
        to_cycle(8);
        #3;
        check("idle_tog", tog, 0);
        check("idle_busy", busy, 0);
        check("idle_remaining", remaining, 0);

        // Basic run: P=3, mask 05, N=4 -> toggles 4 cycles apart.
        do_cfg(16'd3, 8'h05, 8'd4);
        do_start(k);
        for (int i = 1; i <= 4; i++) begin
            push_port(k + 4 * i, 1'b0, 1'b1, 8'h05);
        end
        push_done(k + 17);
        #3;
        check("basic_busy_start", busy, 1);
        check("basic_state_start", dbg_state, 1);
        check("basic_rem_start", remaining, 4);
        to_cycle(k + 5);
        #3;
        check("basic_rem_after1", remaining, 3);
        to_cycle(k + 16);
        #3;
        check("basic_busy_last", busy, 1);
        check("basic_rem_last", remaining, 1);
        to_cycle(k + 17);
        #3;
        check("basic_busy_end", busy, 0);
        check("basic_rem_end", remaining, 0);
        to_cycle(k + 20);

        // Collision: CPU write on the first grant cycle delays that toggle
        // by one cycle; the second toggle keeps the original cadence.
        do_cfg(16'd2, 8'h3C, 8'd2);
        do_start(k);
        push_port(k + 3, 1'b1, 1'b0, 8'hA0);
        push_port(k + 4, 1'b0, 1'b1, 8'h3C);
        push_port(k + 6, 1'b0, 1'b1, 8'h3C);
        push_done(k + 7);
        to_cycle(k + 3);
        cpu_wbe   = 1'b1;
        cpu_wdata = 8'hA0;
        to_cycle(k + 4);
        cpu_wbe   = 1'b0;
        cpu_wdata = 8'h00;
        to_cycle(k + 7);
        #3;
        check("coll_overrun", overrun, 0);
        check("coll_busy_end", busy, 0);
        to_cycle(k + 10);

        // Overrun: P=0, CPU toggles for 3 cycles while a request is pending.
        do_cfg(16'd0, 8'h81, 8'd1);
        do_start(k);
        push_port(k + 1, 1'b0, 1'b1, 8'h11);
        push_port(k + 2, 1'b0, 1'b1, 8'h11);
        push_port(k + 3, 1'b0, 1'b1, 8'h11);
        push_port(k + 4, 1'b0, 1'b1, 8'h81);
        push_done(k + 5);
        to_cycle(k + 1);
        cpu_tog   = 1'b1;
        cpu_wdata = 8'h11;
        #3;
        check("ovr_before", overrun, 0);
        to_cycle(k + 2);
        #3;
        check("ovr_set", overrun, 1);
        to_cycle(k + 4);
        cpu_tog   = 1'b0;
        cpu_wdata = 8'h00;
        to_cycle(k + 5);
        #3;
        check("ovr_sticky", overrun, 1);
        check("ovr_busy_end", busy, 0);
        to_cycle(k + 8);

        // Infinite mode: P=1, N=0; stop lands on the 10th grant cycle.
        do_cfg(16'd1, 8'hF0, 8'd0);
        do_start(k);
        for (int i = 0; i < 10; i++) begin
            push_port(k + 2 + 2 * i, 1'b0, 1'b1, 8'hF0);
        end
        #3;
        check("inf_ovr_cleared", overrun, 0);
        to_cycle(k + 5);
        #3;
        check("inf_remaining", remaining, 0);
        check("inf_busy", busy, 1);
        to_cycle(k + 20);
        stop = 1'b1;
        to_cycle(k + 21);
        stop = 1'b0;
        #3;
        check("inf_busy_stopped", busy, 0);
        check("inf_state_stopped", dbg_state, 0);
        to_cycle(k + 30);

        // Config lockout: cfg_we during a run must not change anything.
        do_cfg(16'd3, 8'h0F, 8'd3);
        do_start(k);
        push_port(k + 4, 1'b0, 1'b1, 8'h0F);
        push_port(k + 8, 1'b0, 1'b1, 8'h0F);
        push_port(k + 12, 1'b0, 1'b1, 8'h0F);
        push_done(k + 13);
        to_cycle(k + 2);
        cfg_we     = 1'b1;
        cfg_period = 16'd7;
        cfg_mask   = 8'hFF;
        cfg_count  = 8'd9;
        to_cycle(k + 3);
        cfg_we     = 1'b0;
        to_cycle(k + 5);
        #3;
        check("lock_remaining", remaining, 2);
        to_cycle(k + 13);
        #3;
        check("lock_busy_end", busy, 0);
        check("lock_rem_end", remaining, 0);
        to_cycle(k + 15);

        // Reset abort mid-run: immediate idle, no done, no further toggles.
        do_cfg(16'd2, 8'h55, 8'd5);
        do_start(k);
        push_port(k + 3, 1'b0, 1'b1, 8'h55);
        push_port(k + 6, 1'b0, 1'b1, 8'h55);
        to_cycle(k + 7);
        nrst = 1'b0;
        #3;
        check("abort_busy", busy, 0);
        check("abort_state", dbg_state, 0);
        check("abort_tog", tog, 0);
        check("abort_wdata", wdata, 0);
        check("abort_remaining", remaining, 0);
        to_cycle(k + 8);
        nrst = 1'b1;
        to_cycle(k + 16);
        #3;
        check("abort_busy_after", busy, 0);
        check("abort_rem_after", remaining, 0);

        check("port_queue_drained", exp_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
